// File: rtl/can_pkg.sv
// Shared types and constants for the CAN transmit path.
// Field lengths here are in unstuffed bits.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } can_state_e;

  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam int EOF_LEN  = 7;
  localparam int IFS_LEN  = 3;
  localparam int ID_LEN   = 11;
  localparam int DLC_LEN  = 4;
  localparam int CRC_LEN  = 15;
  localparam int ARB_LEN  = 1 + ID_LEN + 1;
  localparam int CTRL_LEN = 2 + DLC_LEN;
  localparam int HDR_LEN  = ARB_LEN + CTRL_LEN;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_tx_stuff_unit.sv
// Bit-stuffing stage: tracks the run of identical driven bits and
// substitutes a complement bit once the run reaches RUN_LEN.
module can_tx_stuff_unit
  import can_pkg::*;
#(
  parameter int RUN_LEN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_bit_i,
  input  logic stuff_en_i,
  input  logic bit_tick_i,
  input  logic sof_i,
  output logic line_bit_o,
  output logic advance_o
);

  localparam int CW = $clog2(RUN_LEN + 1);

  logic [CW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic          stuff;

  always_comb begin
    stuff      = stuff_en_i && !sof_i && (run_q == CW'(RUN_LEN));
    line_bit_o = stuff ? ~last_q : frame_bit_i;
    advance_o  = ~stuff;
    run_d      = run_q;
    last_d     = last_q;
    if (bit_tick_i) begin
      // A stuff bit opens a new run, as does any change of level or SOF.
      if (sof_i || stuff || (line_bit_o != last_q)) begin
        run_d  = CW'(1);
        last_d = line_bit_o;
      end else if (run_q != CW'(RUN_LEN)) begin
        run_d = run_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/can_tx_sequencer.sv
// CAN standard data frame transmitter: serializes SOF..IFS one bit per
// bit_tick, with stuffing, CRC-15, arbitration-loss and ACK monitoring.
//
// state       | meaning
// ST_IDLE     | ready for a request
// ST_WAIT_SOF | request captured, SOF goes out on the next tick
// ST_ARB      | last frame bit driven was SOF, ID or RTR
// ST_CTRL     | IDE, r0, DLC
// ST_DATA     | data bits
// ST_CRC      | CRC-15 sequence
// ST_CRC_DEL  | CRC delimiter
// ST_ACK_SLOT | ACK slot (recessive driven, dominant expected)
// ST_ACK_DEL  | ACK delimiter
// ST_EOF      | end of frame
// ST_IFS      | interframe space
module can_tx_sequencer
  import can_pkg::*;
#(
  parameter int RUN_LEN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        rx_bit,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_id,
  input  logic [3:0]  req_dlc,
  input  logic [63:0] req_data,
  output logic        tx_bit,
  output logic        busy,
  output logic        done,
  output logic        arb_lost,
  output logic        ack_err
);

  // state_q/cnt_q locate the last frame bit driven; cnt_q counts down to 0
  // at the final bit of the field.
  can_state_e           state_q, state_d, nxt_state;
  logic [5:0]           cnt_q, cnt_d, nxt_cnt;
  logic [HDR_LEN-1:0]   hdr_q, hdr_d;
  logic [63:0]          data_q, data_d;
  logic [14:0]          crc_q, crc_d;
  logic [6:0]           dbits_q, dbits_d;
  logic                 tx_q, tx_d;
  logic                 stuffed_q, stuffed_d;

  logic frame_bit, stuff_en, sof, drive, line_bit, advance;
  logic eval, lose, noack, fin;

  always_comb begin
    nxt_state = ST_IDLE;
    nxt_cnt   = '0;
    case (state_q)
      ST_WAIT_SOF: begin
        nxt_state = ST_ARB;
        nxt_cnt   = 6'(ARB_LEN - 1);
      end
      ST_ARB: begin
        if (cnt_q == 6'd0) begin
          nxt_state = ST_CTRL;
          nxt_cnt   = 6'(CTRL_LEN - 1);
        end else begin
          nxt_state = ST_ARB;
          nxt_cnt   = cnt_q - 6'd1;
        end
      end
      ST_CTRL: begin
        if (cnt_q != 6'd0) begin
          nxt_state = ST_CTRL;
          nxt_cnt   = cnt_q - 6'd1;
        end else if (dbits_q == 7'd0) begin
          nxt_state = ST_CRC;
          nxt_cnt   = 6'(CRC_LEN - 1);
        end else begin
          nxt_state = ST_DATA;
          nxt_cnt   = 6'(dbits_q - 7'd1);
        end
      end
      ST_DATA: begin
        if (cnt_q == 6'd0) begin
          nxt_state = ST_CRC;
          nxt_cnt   = 6'(CRC_LEN - 1);
        end else begin
          nxt_state = ST_DATA;
          nxt_cnt   = cnt_q - 6'd1;
        end
      end
      ST_CRC: begin
        if (cnt_q == 6'd0) begin
          nxt_state = ST_CRC_DEL;
        end else begin
          nxt_state = ST_CRC;
          nxt_cnt   = cnt_q - 6'd1;
        end
      end
      ST_CRC_DEL:  nxt_state = ST_ACK_SLOT;
      ST_ACK_SLOT: nxt_state = ST_ACK_DEL;
      ST_ACK_DEL: begin
        nxt_state = ST_EOF;
        nxt_cnt   = 6'(EOF_LEN - 1);
      end
      ST_EOF: begin
        if (cnt_q == 6'd0) begin
          nxt_state = ST_IFS;
          nxt_cnt   = 6'(IFS_LEN - 1);
        end else begin
          nxt_state = ST_EOF;
          nxt_cnt   = cnt_q - 6'd1;
        end
      end
      ST_IFS: begin
        nxt_state = ST_IFS;
        nxt_cnt   = cnt_q - 6'd1;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    case (nxt_state)
      ST_ARB, ST_CTRL: frame_bit = hdr_q[HDR_LEN-1];
      ST_DATA:         frame_bit = data_q[63];
      ST_CRC:          frame_bit = crc_q[14];
      default:         frame_bit = 1'b1;
    endcase
    stuff_en = (nxt_state == ST_ARB) || (nxt_state == ST_CTRL) ||
               (nxt_state == ST_DATA) || (nxt_state == ST_CRC);
    sof      = (state_q == ST_WAIT_SOF);
  end

  // Stuff bits in the arbitration field are not arbitration bits.
  assign eval  = bit_tick && (state_q != ST_IDLE) && (state_q != ST_WAIT_SOF);
  assign lose  = eval && (state_q == ST_ARB) && (cnt_q != 6'(ARB_LEN - 1)) &&
                 !stuffed_q && tx_q && !rx_bit;
  assign noack = eval && (state_q == ST_ACK_SLOT) && rx_bit;
  assign fin   = eval && (state_q == ST_IFS) && (cnt_q == 6'd0);
  assign drive = bit_tick && (state_q != ST_IDLE) && !done;

  assign done      = lose || noack || fin;
  assign arb_lost  = lose;
  assign ack_err   = noack;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign tx_bit    = tx_q;

  can_tx_stuff_unit #(.RUN_LEN(RUN_LEN)) u_stuff (
    .clk         (clk),
    .rst         (rst),
    .frame_bit_i (frame_bit),
    .stuff_en_i  (stuff_en),
    .bit_tick_i  (drive),
    .sof_i       (sof),
    .line_bit_o  (line_bit),
    .advance_o   (advance)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    crc_d     = crc_q;
    dbits_d   = dbits_q;
    tx_d      = tx_q;
    stuffed_d = stuffed_q;
    if (state_q == ST_IDLE) begin
      if (req_valid) begin
        state_d = ST_WAIT_SOF;
        cnt_d   = '0;
        hdr_d   = {1'b0, req_id, 3'b000, req_dlc};
        data_d  = req_data;
        crc_d   = '0;
        dbits_d = (req_dlc > 4'd8) ? 7'd64 : {req_dlc, 3'b000};
      end
    end else if (done) begin
      state_d   = ST_IDLE;
      tx_d      = 1'b1;
      stuffed_d = 1'b0;
    end else if (drive) begin
      tx_d      = line_bit;
      stuffed_d = ~advance;
      if (advance) begin
        state_d = nxt_state;
        cnt_d   = nxt_cnt;
        case (nxt_state)
          ST_ARB, ST_CTRL: begin
            hdr_d = {hdr_q[HDR_LEN-2:0], 1'b0};
            crc_d = crc15_step(crc_q, frame_bit);
          end
          ST_DATA: begin
            data_d = {data_q[62:0], 1'b0};
            crc_d  = crc15_step(crc_q, frame_bit);
          end
          ST_CRC:  crc_d = {crc_q[13:0], 1'b0};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      data_q    <= '0;
      crc_q     <= '0;
      dbits_q   <= '0;
      tx_q      <= 1'b1;
      stuffed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      dbits_q   <= dbits_d;
      tx_q      <= tx_d;
      stuffed_q <= stuffed_d;
    end
  end

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Scoreboard bench for can_tx_sequencer: a flat-list frame model queues
// expected line bits and outcomes; a monitor compares what the DUT drives.
module tb_can_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_tick = 1'b0;
  logic        rx_bit = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_id = '0;
  logic [3:0]  req_dlc = '0;
  logic [63:0] req_data = '0;
  logic        tx_bit, busy, done, arb_lost, ack_err;

  can_tx_sequencer #(.RUN_LEN(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_tick  (bit_tick),
    .rx_bit    (rx_bit),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_dlc   (req_dlc),
    .req_data  (req_data),
    .tx_bit    (tx_bit),
    .busy      (busy),
    .done      (done),
    .arb_lost  (arb_lost),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic arb;
    logic ack;
    int   len;
  } res_t;

  logic exp_bits[$];
  res_t exp_res[$];
  logic cap[$];
  logic mb[$];
  int   m_ack, m_arb;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Builds the unstuffed frame as a flat list, then stuffs it.
  function automatic void build(input logic [10:0] id, input logic [3:0] dlc,
                                input logic [63:0] data, input int arb_u);
    logic        u[$];
    logic [14:0] crc;
    logic        b, last;
    int          nb, last_crc, ack_u, run;
    u = {};
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(id[i]);
    u.push_back(1'b0); u.push_back(1'b0); u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nb = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int i = 0; i < nb * 8; i++) u.push_back(data[63-i]);
    crc = '0;
    for (int i = 0; i < u.size(); i++) begin
      b   = u[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (b) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    last_crc = u.size() - 1;
    u.push_back(1'b1);
    ack_u = u.size();
    u.push_back(1'b1);
    u.push_back(1'b1);
    repeat (10) u.push_back(1'b1);
    mb = {}; run = 0; last = 1'b0; m_arb = -1; m_ack = -1;
    for (int i = 0; i < u.size(); i++) begin
      if (i == ack_u) m_ack = mb.size();
      if (i == arb_u) m_arb = mb.size();
      mb.push_back(u[i]);
      if (i > 0 && u[i] == last) run++;
      else begin run = 1; last = u[i]; end
      if (run == 5 && i < last_crc) begin
        mb.push_back(~last);
        last = ~last;
        run  = 1;
      end
    end
  endfunction

  // Monitor: one new line bit follows every non-final tick of a frame.
  initial begin
    logic e;
    res_t r;
    int   fcnt;
    bit   pend;
    pend = 0; fcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; fcnt = 0;
      end else begin
        if (pend) begin
          cap.push_back(tx_bit);
          if (exp_bits.size() == 0) chk("tx_bit_unexpected", 32'(tx_bit), 32'hx);
          else begin
            e = exp_bits.pop_front();
            chk("tx_bit", 32'(tx_bit), 32'(e));
          end
          fcnt++;
        end
        if (done) begin
          if (exp_res.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
          else begin
            r = exp_res.pop_front();
            chk("arb_lost", 32'(arb_lost), 32'(r.arb));
            chk("ack_err", 32'(ack_err), 32'(r.ack));
            chk("frame_bits", 32'(fcnt), 32'(r.len));
          end
          fcnt = 0;
        end
        pend = bit_tick && busy && !done;
      end
    end
  end

  // mode 0: ACK given, 1: ACK slot left recessive, 2: arbitration loss at
  // unstuffed bit arg, 3: reset after tick arg.
  task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc,
                           input logic [63:0] data, input int mode, input int arg);
    int   len, kd;
    res_t r;
    build(id, dlc, data, (mode == 2) ? arg : -1);
    len = (mode == 1) ? m_ack + 1 : (mode == 2) ? m_arb + 1 : mb.size();
    for (int i = 0; i < len; i++) exp_bits.push_back(mb[i]);
    if (mode != 3) begin
      r.arb = (mode == 2); r.ack = (mode == 1); r.len = len;
      exp_res.push_back(r);
    end
    cap.delete();
    for (int w = 0; w < 50 && !req_ready; w++) @(posedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_id = id; req_dlc = dlc; req_data = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_id = 11'($urandom); req_dlc = 4'($urandom); req_data = {$urandom, $urandom};
    chk("ready_drop", 32'(req_ready), 32'd0);
    kd = -1;
    for (int k = 0; k <= len + 4; k++) begin
      repeat (3) @(posedge clk);
      #1;
      rx_bit = 1'b1;
      if (k > 0 && k - 1 < mb.size()) rx_bit = mb[k-1];
      if (mode == 0 && k - 1 == m_ack) rx_bit = 1'b0;
      if (mode == 2 && k - 1 == m_arb) rx_bit = 1'b0;
      bit_tick = 1'b1;
      @(negedge clk);
      if (done) begin
        kd = k;
        chk("ready_at_done", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      bit_tick = 1'b0; rx_bit = 1'b1;
      if (kd >= 0 || (mode == 3 && k == arg)) break;
    end
    if (mode == 3) begin
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_tx_bit", 32'(tx_bit), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'({done, arb_lost, ack_err}), 32'd0);
      exp_bits.delete();
      repeat (2) begin
        @(negedge clk);
        chk("no_done_in_rst", 32'(done), 32'd0);
      end
      #1 rst = 1'b0;
    end else begin
      chk("done_tick", 32'(kd), 32'(len));
      @(negedge clk);
      chk("ready_after_done", 32'(req_ready), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("tx_idle_after_done", 32'(tx_bit), 32'd1);
      if (mode == 2) begin
        repeat (3) @(negedge clk);
        chk("tx_recessive_after_arb", 32'(tx_bit), 32'd1);
      end
    end
  endtask

  initial begin
    logic [17:0] got, gold;
    gold = 18'b000001000001000001;
    #12;
    chk("reset_tx_bit", 32'(tx_bit), 32'd1);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pulses", 32'({done, arb_lost, ack_err}), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_frame(11'h123, 4'd1, 64'hAA00_0000_0000_0000, 0, 0);

    run_frame(11'h000, 4'd0, 64'h0, 0, 0);
    got = '0;
    for (int i = 0; i < 18 && i < cap.size(); i++) got[17-i] = cap[i];
    chk("stuff_pattern_id0", 32'(got), 32'(gold));

    run_frame(11'h7FF, 4'd0, 64'h0, 2, 8);
    run_frame(11'h2A5, 4'd2, 64'hC3F0_0000_0000_0000, 1, 0);
    run_frame(11'h456, 4'd12, 64'h0102030405060708, 0, 0);
    run_frame(11'h055, 4'd2, 64'hFFFF_0000_0000_0000, 3, 25);
    run_frame(11'h055, 4'd2, 64'hFFFF_0000_0000_0000, 0, 0);

    repeat (5) @(posedge clk);
    chk("bits_left_in_scoreboard", 32'(exp_bits.size()), 32'd0);
    chk("results_left_in_scoreboard", 32'(exp_res.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
